// File: rtl/ps2_keycode_fifo.sv
// PS/2 Set-2 scan-code decoder (prefix, shift, caps tracking) feeding an ASCII FIFO
// behind a two-register memory-mapped interface with a level interrupt.
module ps2_keycode_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        code_new_i,
  input  logic [7:0]  code_i,
  input  logic        sel_i,
  input  logic        addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_e;

  // Returns {mapped, ascii}; letters are uppercased when upper is set.
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
      8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
      8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
      8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
      8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
      8'h29: ch = 8'h20; 8'h5A: ch = 8'h0D; 8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
    return {ch != 8'h00, ch};
  endfunction

  state_e             state_q, state_d;
  logic               shift_l_q, shift_l_d, shift_r_q, shift_r_d, caps_q, caps_d;
  logic               ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [7:0]         mem_q [DEPTH];

  logic       push_req, push_ok, pop, flush, data_rd, stat_rd, ctrl_wr, full, room;
  logic [7:0] push_data;
  logic [8:0] xl;
  logic       unused_wdata_c;

  assign unused_wdata_c = ^{wdata_i[31:6], wdata_i[4:3], wdata_i[1]};

  always_comb begin
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    caps_d    = caps_q;
    push_req  = 1'b0;
    push_data = 8'h00;
    xl        = xlate(code_i, (shift_l_q | shift_r_q) ^ caps_q);

    // Prefix/make/break decoding, advanced only on a strobe
    if (code_new_i) begin
      case (state_q)
        ST_IDLE: begin
          if (code_i == 8'hF0)      state_d = ST_BRK;
          else if (code_i == 8'hE0) state_d = ST_EXT;
          else if (code_i == 8'h12) shift_l_d = 1'b1;
          else if (code_i == 8'h59) shift_r_d = 1'b1;
          else if (code_i == 8'h58) caps_d = ~caps_q;
          else begin
            push_req  = xl[8];
            push_data = xl[7:0];
          end
        end
        ST_BRK: begin
          if (code_i == 8'h12) shift_l_d = 1'b0;
          if (code_i == 8'h59) shift_r_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT:  state_d = (code_i == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_rd  = sel_i & re_i & ~addr_i;
    stat_rd  = sel_i & re_i & addr_i;
    ctrl_wr  = sel_i & we_i & addr_i;
    full     = (count_q == CNT_W'(DEPTH));
    pop      = data_rd & (count_q != '0);
    flush    = ctrl_wr & wdata_i[0];
    // Pop frees a slot before the push is judged
    room     = ~full | pop;
    push_ok  = push_req & ~flush & room;

    ovf_d = ovf_q;
    if (ctrl_wr && wdata_i[2]) ovf_d = 1'b0;
    if (push_req && !flush && !room) ovf_d = 1'b1;
    irq_en_d = ctrl_wr ? wdata_i[5] : irq_en_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    rdata_d = rdata_q;
    if (data_rd) rdata_d = pop ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
    if (stat_rd) rdata_d = {16'h0, 8'(count_q), 2'b00, irq_en_q, caps_q,
                            shift_l_q | shift_r_q, ovf_q, full, count_q != '0};
    irq_d = irq_en_d & (count_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      caps_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      caps_q    <= caps_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage array needs no reset; occupancy is tracked by count
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Directed bench for ps2_keycode_fifo: vector table of scan codes / reads plus corner sequences.
module tb_ps2_keycode_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        code_new_i = 1'b0;
  logic [7:0]  code_i = 8'h00;
  logic        sel_i = 1'b0, addr_i = 1'b0, we_i = 1'b0, re_i = 1'b0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  ps2_keycode_fifo #(.DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .code_new_i(code_new_i), .code_i(code_i),
    .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i), .re_i(re_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       is_rd;
    logic [7:0] val;
    logic [6:0] cnt;
    logic       sh;
    logic       cp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic is_rd, input logic [7:0] val, input int cnt,
                     input logic sh, input logic cp);
    vec_t v;
    v.is_rd = is_rd; v.val = val; v.cnt = 7'(cnt); v.sh = sh; v.cp = cp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk_i);
    code_new_i = 1'b1; code_i = c;
    @(negedge clk_i);
    code_new_i = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; re_i = 1'b1; addr_i = a;
    @(negedge clk_i);
    sel_i = 1'b0; re_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic ctrl(input logic [31:0] w);
    @(negedge clk_i);
    sel_i = 1'b1; we_i = 1'b1; addr_i = 1'b1; wdata_i = w;
    @(negedge clk_i);
    sel_i = 1'b0; we_i = 1'b0; wdata_i = 32'h0;
  endtask

  logic [31:0] d;
  logic [8:0]  act9, exp9;

  initial begin
    // shift/caps/prefix walk: code entries check STATUS, read entries check DATA then STATUS
    add(0,8'h12,0,1,0); add(0,8'h1C,1,1,0); add(0,8'hF0,1,1,0); add(0,8'h1C,1,1,0);
    add(0,8'hF0,1,1,0); add(0,8'h12,1,0,0); add(0,8'h1C,2,0,0);
    add(1,8'h41,1,0,0); add(1,8'h61,0,0,0);
    add(0,8'h58,0,0,1); add(0,8'hF0,0,0,1); add(0,8'h58,0,0,1); add(0,8'h32,1,0,1);
    add(0,8'h12,1,1,1); add(0,8'h32,2,1,1); add(0,8'hF0,2,1,1); add(0,8'h12,2,0,1);
    add(0,8'h58,2,0,0); add(1,8'h42,1,0,0); add(1,8'h62,0,0,0);
    add(0,8'hE0,0,0,0); add(0,8'h75,0,0,0); add(0,8'hE0,0,0,0); add(0,8'hF0,0,0,0);
    add(0,8'h75,0,0,0); add(0,8'h29,1,0,0); add(0,8'h00,1,0,0);
    add(0,8'h59,1,1,0); add(0,8'h1C,2,1,0); add(0,8'hE0,2,1,0); add(0,8'h12,2,1,0);
    add(0,8'hF0,2,1,0); add(0,8'h59,2,0,0); add(0,8'h45,3,0,0);
    add(1,8'h20,2,0,0); add(1,8'h41,1,0,0); add(1,8'h30,0,0,0); add(1,8'h00,0,0,0);
    add(0,8'h66,1,0,0); add(0,8'h5A,2,0,0); add(1,8'h08,1,0,0); add(1,8'h0D,0,0,0);
    add(0,8'h12,0,1,0); add(0,8'h16,1,1,0); add(1,8'h31,0,1,0);
    add(0,8'hF0,0,1,0); add(0,8'h12,0,0,0);

    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    rd(1'b1, d); chk("reset_status", d, 32'h0);

    send(8'h1C); send(8'hF0); send(8'h1C);
    rd(1'b1, d); chk("brk_one_entry", d, 32'h101);
    rd(1'b0, d); chk("brk_data", d, 32'h61);
    rd(1'b1, d); chk("brk_status_after", d, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_rd) begin
        rd(1'b0, d);
        chk($sformatf("vec%0d_data", i), d, {24'h0, vecs[i].val});
      end else begin
        send(vecs[i].val);
      end
      rd(1'b1, d);
      act9 = {d[14:8], d[4], d[3]};
      exp9 = {vecs[i].cnt, vecs[i].cp, vecs[i].sh};
      chk($sformatf("vec%0d_status", i), 32'(act9), 32'(exp9));
    end

    // Overflow: nine pushes into eight slots
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
    rd(1'b1, d); chk("full_ovf_status", d, 32'h807);
    @(negedge clk_i);
    code_new_i = 1'b1; code_i = 8'h3B; sel_i = 1'b1; re_i = 1'b1; addr_i = 1'b0;
    @(negedge clk_i);
    code_new_i = 1'b0; sel_i = 1'b0; re_i = 1'b0;
    chk("full_pop_push_data", rdata_o, 32'h61);
    rd(1'b1, d); chk("full_pop_push_status", d, 32'h807);
    ctrl(32'h05);
    rd(1'b1, d); chk("flush_status", d, 32'h0);

    // Interrupt path and asynchronous reset mid-break
    ctrl(32'h20);
    chk("irq_empty", {31'h0, irq_o}, 32'h0);
    send(8'h45);
    @(negedge clk_i);
    chk("irq_set", {31'h0, irq_o}, 32'h1);
    rd(1'b0, d); chk("irq_data", d, 32'h30);
    @(negedge clk_i);
    chk("irq_clear", {31'h0, irq_o}, 32'h0);
    rd(1'b1, d); chk("irq_en_status", d, 32'h20);
    send(8'h1C); send(8'hF0);
    chk("pre_rst_irq", {31'h0, irq_o}, 32'h1);
    chk("pre_rst_rdata", rdata_o, 32'h20);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_irq", {31'h0, irq_o}, 32'h0);
    chk("async_rst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    send(8'h1C);
    rd(1'b1, d); chk("post_rst_make_status", d, 32'h101);
    rd(1'b0, d); chk("post_rst_make_data", d, 32'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
